// File: rtl/atan2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : atan2_arbiter
// Purpose  : Shares a single atan2 core among N_REQ requesters. One operand
//            pair is accepted at a time under a round-robin grant, issued to
//            the core, and the core's angle is returned to the granted
//            requester only. Operands and angle pass through bit-exact.
// Ports    : clk_i, reset_i       clock, synchronous active-high reset
//            req_valid_i/ready_o  per-requester handshake (ready one-hot)
//            req_num_i/req_den_i  packed operands, requester k at [k*IN_DW +: IN_DW]
//            resp_angle_o         returned angle (held until next response)
//            resp_valid_o         one-hot single-cycle response strobe
//            resp_err_o           timeout flag, qualified by resp_valid_o
//            atan_num_o/den_o     operands to the core
//            atan_valid_o         single-cycle issue strobe to the core
//            atan_angle_i/valid_i core result
//            busy_o               high whenever not IDLE
// Options  : define ATAN_ARB_TIMEOUT_EN to bound the WAIT state to
//            TIMEOUT_CYC cycles (error response on expiry).
// Revision : 1.0 - initial release
// ============================================================================
module atan2_arbiter #(
    parameter int N_REQ       = 2,
    parameter int IN_DW       = 8,
    parameter int OUT_DW      = 20,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*IN_DW-1:0]  req_num_i,
    input  logic [N_REQ*IN_DW-1:0]  req_den_i,
    output logic [OUT_DW-1:0]       resp_angle_o,
    output logic [N_REQ-1:0]        resp_valid_o,
    output logic                    resp_err_o,
    output logic [IN_DW-1:0]        atan_num_o,
    output logic [IN_DW-1:0]        atan_den_o,
    output logic                    atan_valid_o,
    input  logic [OUT_DW-1:0]       atan_angle_i,
    input  logic                    atan_valid_i,
    output logic                    busy_o
);

    localparam int c_PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_SCAN_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [c_PTR_W-1:0]     r_rr_ptr;
    logic [c_PTR_W-1:0]     r_gnt;
    logic [IN_DW-1:0]       r_num;
    logic [IN_DW-1:0]       r_den;
    logic [OUT_DW-1:0]      r_angle;

    logic [N_REQ-1:0]       w_grant_oh;
    logic [c_PTR_W-1:0]     w_grant_idx;
    logic                   w_found;
    logic [c_SCAN_W-1:0]    w_scan;
    logic                   w_handshake;
    logic [c_SCAN_W-1:0]    w_ptr_inc;
    logic [c_PTR_W-1:0]     w_ptr_nxt;
    logic                   w_timeout;

    // ------------------------------------------------------------------
    // Round-robin search: first valid requester at or above r_rr_ptr,
    // wrapping modulo N_REQ (N_REQ need not be a power of two).
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_oh  = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_scan      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_scan = {1'b0, r_rr_ptr} + c_SCAN_W'(i);
            if (w_scan >= c_SCAN_W'(N_REQ)) begin
                w_scan = w_scan - c_SCAN_W'(N_REQ);
            end
            if (!w_found && req_valid_i[w_scan[c_PTR_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_scan[c_PTR_W-1:0];
            end
        end
        if (w_found) begin
            w_grant_oh[w_grant_idx] = 1'b1;
        end
    end

    // Ready is only offered in IDLE, so valid & ready reduces to this.
    assign w_handshake = (r_state == S_IDLE) && w_found;

    assign w_ptr_inc = {1'b0, w_grant_idx} + c_SCAN_W'(1);
    assign w_ptr_nxt = (w_ptr_inc >= c_SCAN_W'(N_REQ)) ? '0 : w_ptr_inc[c_PTR_W-1:0];

    // ------------------------------------------------------------------
    // Optional WAIT watchdog. The counter is 0 in the first WAIT cycle,
    // so expiry fires in the TIMEOUT_CYC-th WAIT cycle. A core result in
    // that same cycle wins over the timeout.
    // ------------------------------------------------------------------
`ifdef ATAN_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_CNT_W-1:0]     r_wait_cnt;
    logic                   r_err;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !atan_valid_i &&
                       (r_wait_cnt == c_CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_err <= 1'b0;
        end else if (r_state == S_WAIT) begin
            if (atan_valid_i) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign resp_err_o = (r_state == S_RESP) && r_err;
`else
    assign w_timeout  = 1'b0;
    assign resp_err_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_handshake) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (atan_valid_i || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_num    <= '0;
            r_den    <= '0;
            r_angle  <= '0;
        end else begin
            if (w_handshake) begin
                r_gnt    <= w_grant_idx;
                r_rr_ptr <= w_ptr_nxt;
                r_num    <= req_num_i[w_grant_idx*IN_DW +: IN_DW];
                r_den    <= req_den_i[w_grant_idx*IN_DW +: IN_DW];
            end
            if (r_state == S_WAIT) begin
                if (atan_valid_i) begin
                    r_angle <= atan_angle_i;
                end else if (w_timeout) begin
                    r_angle <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready_o  = (r_state == S_IDLE) ? w_grant_oh : '0;
    assign atan_valid_o = (r_state == S_ISSUE);
    assign atan_num_o   = r_num;
    assign atan_den_o   = r_den;
    assign resp_angle_o = r_angle;
    assign busy_o       = (r_state != S_IDLE);

    always_comb begin
        resp_valid_o = '0;
        if (r_state == S_RESP) begin
            resp_valid_o[r_gnt] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_atan2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_atan2_arbiter
// Purpose  : Directed self-checking bench for atan2_arbiter (N_REQ=4) with a
//            stub atan2 core whose result is num*1000+den after a
//            programmable latency (default 3 cycles from the issue cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_atan2_arbiter;

    localparam int N   = 4;
    localparam int IW  = 8;
    localparam int OW  = 20;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*IW-1:0]   req_num_i;
    logic [N*IW-1:0]   req_den_i;
    logic [OW-1:0]     resp_angle_o;
    logic [N-1:0]      resp_valid_o;
    logic              resp_err_o;
    logic [IW-1:0]     atan_num_o;
    logic [IW-1:0]     atan_den_o;
    logic              atan_valid_o;
    logic [OW-1:0]     atan_angle_i = '0;
    logic              atan_valid_i = 1'b0;
    logic              busy_o;

    int total = 0;
    int bad   = 0;

    // stub core controls
    logic              stub_en        = 1'b1;
    int                stub_lat       = 3;
    logic              stub_force     = 1'b0;
    logic [OW-1:0]     stub_force_val = '0;
    int                st_cnt         = 0;
    logic [OW-1:0]     st_val         = '0;

    always #5 clk = ~clk;

    atan2_arbiter #(
        .N_REQ       (N),
        .IN_DW       (IW),
        .OUT_DW      (OW),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_num_i    (req_num_i),
        .req_den_i    (req_den_i),
        .resp_angle_o (resp_angle_o),
        .resp_valid_o (resp_valid_o),
        .resp_err_o   (resp_err_o),
        .atan_num_o   (atan_num_o),
        .atan_den_o   (atan_den_o),
        .atan_valid_o (atan_valid_o),
        .atan_angle_i (atan_angle_i),
        .atan_valid_i (atan_valid_i),
        .busy_o       (busy_o)
    );

    // Stub core: sees the issue strobe mid-cycle, answers stub_lat cycles later.
    always begin
        int n;
        int d;
        @(negedge clk);
        atan_valid_i = 1'b0;
        if (st_cnt > 0) begin
            st_cnt = st_cnt - 1;
            if (st_cnt == 0) begin
                atan_valid_i = 1'b1;
                atan_angle_i = st_val;
            end
        end
        if (atan_valid_o && stub_en) begin
            n      = $signed(atan_num_o);
            d      = $signed(atan_den_o);
            st_cnt = stub_lat;
            st_val = stub_force ? stub_force_val : OW'(n * 1000 + d);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [IW-1:0] num, input logic [IW-1:0] den);
        req_num_i[k*IW +: IW] = num;
        req_den_i[k*IW +: IW] = den;
    endtask

    // Waits (bounded) for a response strobe; cyc counts negedges waited.
    task automatic wait_resp(input int limit, output logic [N-1:0] rv,
                             output logic [OW-1:0] ang, output logic err, output int cyc);
        rv  = '0;
        ang = '0;
        err = 1'b0;
        cyc = 0;
        while (cyc < limit) begin
            @(negedge clk);
            #1;
            cyc++;
            if (resp_valid_o != '0) begin
                rv  = resp_valid_o;
                ang = resp_angle_o;
                err = resp_err_o;
                return;
            end
        end
        total++;
        bad++;
        $error("FAIL wait_resp: observed=no response expected=response within %0d cycles", limit);
    endtask

    initial begin
        #200000;
        bad++;
        $error("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0]  rv;
        logic [OW-1:0] ang;
        logic          err;
        int            cyc;
        int            served [N];
        int            seen;
        int            k;

        reset_i     = 1'b1;
        req_valid_i = '0;
        req_num_i   = '0;
        req_den_i   = '0;
        repeat (3) @(negedge clk);
        #1;
        // ---------------- reset state ----------------
        chk("rst_ready",      32'(req_ready_o),  32'h0);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'h0);
        chk("rst_err",        32'(resp_err_o),   32'h0);
        chk("rst_angle",      32'(resp_angle_o), 32'h0);
        chk("rst_atan_valid", 32'(atan_valid_o), 32'h0);
        chk("rst_atan_num",   32'(atan_num_o),   32'h0);
        chk("rst_atan_den",   32'(atan_den_o),   32'h0);
        chk("rst_busy",       32'(busy_o),       32'h0);
        reset_i = 1'b0;

        // ---------------- single request ----------------
        @(negedge clk);
        set_req(0, 8'd5, 8'd7);
        req_valid_i = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready_o), 32'h1);
        @(negedge clk);
        req_valid_i = '0;
        #1;
        chk("t1_issue_valid", 32'(atan_valid_o), 32'h1);
        chk("t1_issue_num",   32'(atan_num_o),   32'd5);
        chk("t1_issue_den",   32'(atan_den_o),   32'd7);
        chk("t1_issue_ready", 32'(req_ready_o),  32'h0);
        chk("t1_issue_busy",  32'(busy_o),       32'h1);
        wait_resp(20, rv, ang, err, cyc);
        chk("t1_latency", 32'(cyc), 32'd4);
        chk("t1_rv",      32'(rv),  32'h1);
        chk("t1_angle",   32'(ang), 32'd5007);
        chk("t1_err",     32'(err), 32'h0);
        @(negedge clk);
        #1;
        chk("t1_rv_drop",   32'(resp_valid_o), 32'h0);
        chk("t1_ang_hold",  32'(resp_angle_o), 32'd5007);
        chk("t1_idle_busy", 32'(busy_o),       32'h0);

        // ---------------- contention, two requesters ----------------
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        set_req(0, 8'd1, 8'd2);
        set_req(1, 8'd3, 8'd4);
        req_valid_i = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            wait_resp(30, rv, ang, err, cyc);
            chk("t2_rv",    32'(rv),  (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("t2_angle", 32'(ang), (i % 2 == 0) ? 32'd1002 : 32'd3004);
        end
        req_valid_i = '0;

        // ---------------- fairness, four requesters ----------------
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        for (int j = 0; j < N; j++) begin
            set_req(j, IW'(j + 1), IW'(10 + j));
            served[j] = 0;
        end
        req_valid_i = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            k = i % 4;
            wait_resp(30, rv, ang, err, cyc);
            chk("t3_rv",    32'(rv),  32'(1 << k));
            chk("t3_angle", 32'(ang), 32'((k + 1) * 1000 + 10 + k));
            for (int j = 0; j < N; j++) begin
                if (rv[j]) served[j]++;
            end
        end
        req_valid_i = '0;
        for (int j = 0; j < N; j++) begin
            chk("t3_served", 32'(served[j]), 32'd3);
        end

        // ---------------- signed pass-through ----------------
        @(negedge clk);
        set_req(0, 8'h80, 8'h7F);
        stub_force     = 1'b1;
        stub_force_val = 20'hFFFFF;
        req_valid_i    = 4'b0001;
        @(negedge clk);
        req_valid_i = '0;
        #1;
        chk("t4_issue_valid", 32'(atan_valid_o), 32'h1);
        chk("t4_num",         32'(atan_num_o),   32'h80);
        chk("t4_den",         32'(atan_den_o),   32'h7F);
        wait_resp(20, rv, ang, err, cyc);
        chk("t4_rv",    32'(rv),  32'h1);
        chk("t4_angle", 32'(ang), 32'h000FFFFF);
        stub_force = 1'b0;

        // ---------------- reset in WAIT ----------------
        @(negedge clk);
        set_req(2, 8'd9, 8'd9);
        req_valid_i = 4'b0100;
        @(negedge clk);
        req_valid_i = '0;
        #1;
        chk("t5_issue_valid", 32'(atan_valid_o), 32'h1);
        @(negedge clk);              // WAIT cycle 1
        @(negedge clk);              // WAIT cycle 2
        reset_i = 1'b1;
        @(negedge clk);              // core result arrives now, DUT in reset state
        reset_i = 1'b0;
        #1;
        chk("t5_ready",      32'(req_ready_o),  32'h0);
        chk("t5_resp_valid", 32'(resp_valid_o), 32'h0);
        chk("t5_atan_valid", 32'(atan_valid_o), 32'h0);
        chk("t5_atan_num",   32'(atan_num_o),   32'h0);
        chk("t5_atan_den",   32'(atan_den_o),   32'h0);
        chk("t5_angle",      32'(resp_angle_o), 32'h0);
        chk("t5_err",        32'(resp_err_o),   32'h0);
        chk("t5_busy",       32'(busy_o),       32'h0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (resp_valid_o != '0) seen++;
        end
        chk("t5_no_resp", 32'(seen), 32'h0);
        set_req(0, 8'd2, 8'd3);
        set_req(3, 8'd4, 8'd5);
        req_valid_i = 4'b1001;
        #1;
        chk("t5_ptr_reset", 32'(req_ready_o), 32'h1);
        wait_resp(20, rv, ang, err, cyc);
        chk("t5_rv",    32'(rv),  32'h1);
        chk("t5_angle", 32'(ang), 32'd2003);
        req_valid_i = '0;

`ifdef ATAN_ARB_TIMEOUT_EN
        // ---------------- timeout ----------------
        @(negedge clk);
        stub_en = 1'b0;
        set_req(1, 8'd6, 8'd7);
        req_valid_i = 4'b0010;
        @(negedge clk);
        req_valid_i = '0;
        #1;
        chk("t6_issue_valid", 32'(atan_valid_o), 32'h1);
        wait_resp(100, rv, ang, err, cyc);
        chk("t6_to_cycles", 32'(cyc), 32'd65);
        chk("t6_to_rv",     32'(rv),  32'h2);
        chk("t6_to_angle",  32'(ang), 32'h0);
        chk("t6_to_err",    32'(err), 32'h1);
        stub_en  = 1'b1;
        stub_lat = 64;
        @(negedge clk);
        req_valid_i = 4'b0010;
        @(negedge clk);
        req_valid_i = '0;
        #1;
        wait_resp(100, rv, ang, err, cyc);
        chk("t6_late_cycles", 32'(cyc), 32'd65);
        chk("t6_late_rv",     32'(rv),  32'h2);
        chk("t6_late_angle",  32'(ang), 32'd6007);
        chk("t6_late_err",    32'(err), 32'h0);
        stub_lat = 3;
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
